// File: rtl/fc_layer_seq.sv
// fc_layer_seq: time-multiplexed fully-connected layer.
// One MAC per cycle over N_IN inputs for each of N_OUT neurons, with writable
// weight/bias storage, rescale + saturate + optional ReLU, and a valid/ready
// result stream.
module fc_layer_seq #(
    parameter int N_IN      = 9,
    parameter int N_OUT     = 4,
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 40,
    parameter int FRAC_BITS = 0,
    parameter int AW        = $clog2(N_OUT*N_IN+N_OUT),
    localparam int IDX_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_we,
    input  logic [AW-1:0]            w_addr,
    input  logic signed [DATA_W-1:0] w_data,
    input  logic                     start,
    input  logic                     relu_en,
    input  logic [N_IN*DATA_W-1:0]   in_vec,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     done
);

    localparam int DEPTH = N_OUT*N_IN + N_OUT;
    localparam int I_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [I_W-1:0]   LAST_I = I_W'(N_IN-1);
    localparam logic [IDX_W-1:0] LAST_J = IDX_W'(N_OUT-1);
    localparam logic signed [ACC_W-1:0] MAX_V =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT, FIN} state_t;

    state_t                    state_q, state_d;
    logic [I_W-1:0]            i_q, i_d;
    logic [IDX_W-1:0]          j_q, j_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [N_IN*DATA_W-1:0]    in_q, in_d;
    logic                      relu_q, relu_d;
    logic                      busy_q, busy_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0]  out_data_q, out_data_d;
    logic [IDX_W-1:0]          out_idx_q, out_idx_d;
    logic                      done_q, done_d;

    // weights at j*N_IN+i, biases after them; deliberately not reset
    logic signed [DATA_W-1:0]  mem [DEPTH];

    logic [AW-1:0]             w_rd, b_rd;
    logic signed [DATA_W-1:0]  x_sel, w_sel, b_sel;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   bias_acc;

    // rescale, saturate to DATA_W, then clamp negatives when ReLU is on
    function automatic logic signed [DATA_W-1:0] post(
        input logic signed [ACC_W-1:0] a,
        input logic                    relu
    );
        logic signed [ACC_W-1:0] r;
        logic signed [DATA_W-1:0] s;
        r = a >>> FRAC_BITS;
        if (r > MAX_V)      s = MAX_V[DATA_W-1:0];
        else if (r < MIN_V) s = MIN_V[DATA_W-1:0];
        else                s = r[DATA_W-1:0];
        if (relu && s < 0)  s = '0;
        return s;
    endfunction

    // parameter writes only land while idle and in range
    always_ff @(posedge clk) begin
        if (state_q == IDLE && w_we && int'(w_addr) < DEPTH)
            mem[w_addr] <= w_data;
    end

    // operand fetch: current weight/input, and the bias for the neuron about to start
    always_comb begin
        w_rd     = AW'(int'(j_q)*N_IN + int'(i_q));
        b_rd     = AW'(N_OUT*N_IN +
                       ((state_q == OUT && j_q != LAST_J) ? int'(j_q) + 1 : 0));
        x_sel    = in_q[int'(i_q)*DATA_W +: DATA_W];
        w_sel    = mem[w_rd];
        b_sel    = mem[b_rd];
        prod     = x_sel * w_sel;
        bias_acc = ACC_W'(b_sel) <<< FRAC_BITS;
    end

    // next-state and datapath control
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        acc_d       = acc_q;
        in_d        = in_q;
        relu_d      = relu_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    in_d    = in_vec;
                    relu_d  = relu_en;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = bias_acc;
                    busy_d  = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                if (i_q == LAST_I) begin
                    out_valid_d = 1'b1;
                    out_idx_d   = j_q;
                    out_data_d  = post(acc_d, relu_q);
                    state_d     = OUT;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (j_q == LAST_J) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        j_d     = j_q + 1'b1;
                        i_d     = '0;
                        acc_d   = bias_acc;
                        state_d = MAC;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            in_q        <= '0;
            relu_q      <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            acc_q       <= acc_d;
            in_q        <= in_d;
            relu_q      <= relu_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign done      = done_q;

endmodule
